// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: load/store unit between the core data port and a word-only
// synchronous RAM. Loads are extracted and sign/zero extended per byte lane.
// Sub-word stores use read-modify-write. Misaligned or invalid requests are
// rejected. STALL holds the core while a multi-cycle access is in flight.
module lsu_mem_bridge #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_VALID,
  input  logic                  REQ_WE,
  input  logic [2:0]            REQ_FUNCT3,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [SIZE-1:0]       REQ_WDATA,
  output logic                  STALL,
  output logic                  RSP_VALID,
  output logic [SIZE-1:0]       RSP_RDATA,
  output logic                  ACC_ERR,
  output logic [ADDR_WIDTH-3:0] RAM_ADDR,
  output logic                  RAM_RE,
  output logic                  RAM_WE,
  output logic [SIZE-1:0]       RAM_WDATA,
  input  logic [SIZE-1:0]       RAM_RDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RMW_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [15:0]           r_wdata;

  logic                  w_loadFunct;
  logic                  w_storeFunct;
  logic                  w_misaligned;
  logic                  w_reqErr;
  logic                  w_reqLoad;
  logic                  w_reqSw;
  logic                  w_reqRmw;
  logic [7:0]            w_laneByte;
  logic [15:0]           w_laneHalf;
  logic [SIZE-1:0]       w_loadData;
  logic [SIZE-1:0]       w_mergeData;

  // Classify the incoming request: legal load, full-word store, sub-word store or error
  always_comb begin
    w_loadFunct  = !REQ_WE && (REQ_FUNCT3 == 3'd0 || REQ_FUNCT3 == 3'd1 ||
                               REQ_FUNCT3 == 3'd2 || REQ_FUNCT3 == 3'd4 ||
                               REQ_FUNCT3 == 3'd5);
    w_storeFunct = REQ_WE && (REQ_FUNCT3 == 3'd0 || REQ_FUNCT3 == 3'd1 ||
                              REQ_FUNCT3 == 3'd2);
    w_misaligned = ((REQ_FUNCT3[1:0] == 2'd1) && REQ_ADDR[0]) ||
                   ((REQ_FUNCT3[1:0] == 2'd2) && (REQ_ADDR[1:0] != 2'b00));
    w_reqErr     = REQ_VALID && (!(w_loadFunct || w_storeFunct) || w_misaligned);
    w_reqLoad    = REQ_VALID && w_loadFunct && !w_misaligned;
    w_reqSw      = REQ_VALID && w_storeFunct && !w_misaligned && (REQ_FUNCT3[1:0] == 2'd2);
    w_reqRmw     = REQ_VALID && w_storeFunct && !w_misaligned && (REQ_FUNCT3[1:0] != 2'd2);
  end

  // Pick the addressed lane out of the returned word and extend it to a full word
  always_comb begin
    w_laneByte = RAM_RDATA[{r_addr[1:0], 3'b000} +: 8];
    w_laneHalf = RAM_RDATA[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3)
      3'd0:    w_loadData = {{(SIZE-8){w_laneByte[7]}}, w_laneByte};
      3'd1:    w_loadData = {{(SIZE-16){w_laneHalf[15]}}, w_laneHalf};
      3'd4:    w_loadData = {{(SIZE-8){1'b0}}, w_laneByte};
      3'd5:    w_loadData = {{(SIZE-16){1'b0}}, w_laneHalf};
      default: w_loadData = RAM_RDATA;
    endcase
  end

  // Overlay the latched store data onto the old word for the write-back half of RMW
  always_comb begin
    w_mergeData = RAM_RDATA;
    if (r_funct3[1:0] == 2'd0) begin
      w_mergeData[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_mergeData[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // Drive core handshake and RAM strobes from the state; strobes are gated off during reset
  always_comb begin
    STALL     = 1'b0;
    RSP_VALID = 1'b0;
    ACC_ERR   = 1'b0;
    RAM_RE    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_ADDR  = r_addr[ADDR_WIDTH-1:2];
    RAM_WDATA = w_mergeData;
    case (r_state)
      S_IDLE: begin
        RAM_ADDR  = REQ_ADDR[ADDR_WIDTH-1:2];
        RAM_WDATA = REQ_WDATA;
        RAM_WE    = w_reqSw;
        RAM_RE    = w_reqLoad || w_reqRmw;
        STALL     = w_reqLoad || w_reqRmw || w_reqErr;
      end
      S_RD_WAIT:  STALL     = 1'b1;
      S_RMW_WAIT: RAM_WE    = 1'b1;
      S_DONE:     RSP_VALID = 1'b1;
      S_ERR:      ACC_ERR   = 1'b1;
      default:    STALL     = 1'b0;
    endcase
    if (!RESET_N) begin
      STALL     = 1'b0;
      RSP_VALID = 1'b0;
      ACC_ERR   = 1'b0;
      RAM_RE    = 1'b0;
      RAM_WE    = 1'b0;
    end
  end

  // Sequence multi-cycle accesses and capture the request fields they need later
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_funct3  <= '0;
      r_wdata   <= '0;
      RSP_RDATA <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_reqErr) begin
            r_state <= S_ERR;
          end else if (w_reqLoad) begin
            r_addr   <= REQ_ADDR;
            r_funct3 <= REQ_FUNCT3;
            r_state  <= S_RD_WAIT;
          end else if (w_reqRmw) begin
            r_addr   <= REQ_ADDR;
            r_funct3 <= REQ_FUNCT3;
            r_wdata  <= REQ_WDATA[15:0];
            r_state  <= S_RMW_WAIT;
          end
        end
        S_RD_WAIT: begin
          RSP_RDATA <= w_loadData;
          r_state   <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb_lsu_mem_bridge: drives directed and random memory requests, keeps a
// word-array reference memory, and checks responses and RAM writes through
// scoreboard queues drained by an independent monitor.
module tb_lsu_mem_bridge;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        REQ_VALID;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [9:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        STALL;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        ACC_ERR;
  logic [7:0]  RAM_ADDR;
  logic        RAM_RE;
  logic        RAM_WE;
  logic [31:0] RAM_WDATA;
  logic [31:0] RAM_RDATA;

  typedef struct {
    logic        isErr;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  rsp_t        rspQ[$];
  wr_t         wrQ[$];
  logic [31:0] refMem [0:255];
  logic [31:0] ram    [0:255];
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  lsu_mem_bridge #(.SIZE(32), .ADDR_WIDTH(10)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_WE     (REQ_WE),
    .REQ_FUNCT3 (REQ_FUNCT3),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .STALL      (STALL),
    .RSP_VALID  (RSP_VALID),
    .RSP_RDATA  (RSP_RDATA),
    .ACC_ERR    (ACC_ERR),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_RE     (RAM_RE),
    .RAM_WE     (RAM_WE),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_RDATA  (RAM_RDATA)
  );

  // Deterministic initial memory image shared by the RAM model and the reference
  function automatic logic [31:0] initWord(input int idx);
    if (idx == 5) return 32'h87654321;
    return (idx * 32'h01010101) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous word RAM: read data appears the cycle after RAM_RE
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = initWord(i);
    RAM_RDATA = '0;
    forever begin
      @(posedge CLK);
      if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
      if (RAM_RE) RAM_RDATA <= ram[RAM_ADDR];
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference load: shift the addressed lane down and extend by arithmetic
  function automatic logic [31:0] refLoad(input logic [9:0] a, input logic [2:0] f3);
    logic [31:0] word;
    logic [31:0] b;
    logic [31:0] h;
    int          sh;
    word = refMem[a[9:2]];
    sh   = int'(a[1:0]) * 8;
    b    = (word >> sh) & 32'hFF;
    h    = (word >> sh) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // Monitor: whenever the DUT presents a response or a RAM write, pop and compare
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (RAM_RE || RAM_WE) checkVal("strobeExclusive", {31'b0, RAM_RE && RAM_WE}, 32'd0);
      if (RSP_VALID || ACC_ERR) begin
        if (rspQ.size() == 0) begin
          checkVal("unexpectedResponse", {30'b0, RSP_VALID, ACC_ERR}, 32'd0);
        end else begin
          rsp_t e;
          e = rspQ.pop_front();
          checkVal("rspIsErr", {31'b0, ACC_ERR}, {31'b0, e.isErr});
          checkVal("rspValid", {31'b0, RSP_VALID}, {31'b0, !e.isErr});
          if (!e.isErr) checkVal("rspData", RSP_RDATA, e.data);
        end
      end
      if (RAM_WE) begin
        if (wrQ.size() == 0) begin
          checkVal("unexpectedWrite", {24'b0, RAM_ADDR}, 32'hFFFFFFFF);
        end else begin
          wr_t w;
          w = wrQ.pop_front();
          checkVal("wrAddr", {24'b0, RAM_ADDR}, {24'b0, w.addr});
          checkVal("wrData", RAM_WDATA, w.data);
        end
      end
    end
  end

  // Issue one request, push its expected outcome, check first-cycle strobes and stall length
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [9:0] addr, input logic [31:0] wdata);
    logic        okFunct;
    logic        mis;
    int          expStall;
    logic        expRe;
    logic        expWe;
    int          n;
    logic [31:0] mask;
    logic [31:0] merged;
    int          sh;
    okFunct = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis     = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    expRe   = 1'b0;
    expWe   = 1'b0;
    if (!okFunct || mis) begin
      rspQ.push_back('{isErr: 1'b1, data: 32'd0});
      expStall = 1;
    end else if (!we) begin
      rspQ.push_back('{isErr: 1'b0, data: refLoad(addr, f3)});
      expStall = 2;
      expRe    = 1'b1;
    end else if (f3 == 3'd2) begin
      refMem[addr[9:2]] = wdata;
      wrQ.push_back('{addr: addr[9:2], data: wdata});
      expStall = 0;
      expWe    = 1'b1;
    end else begin
      sh     = int'(addr[1:0]) * 8;
      mask   = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
      merged = (refMem[addr[9:2]] & ~mask) | ((wdata << sh) & mask);
      refMem[addr[9:2]] = merged;
      wrQ.push_back('{addr: addr[9:2], data: merged});
      expStall = 1;
      expRe    = 1'b1;
    end
    @(posedge CLK);
    #1;
    REQ_VALID  = 1'b1;
    REQ_WE     = we;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = addr;
    REQ_WDATA  = wdata;
    @(negedge CLK);
    checkVal("firstRe", {31'b0, RAM_RE}, {31'b0, expRe});
    checkVal("firstWe", {31'b0, RAM_WE}, {31'b0, expWe});
    if (expRe || expWe) checkVal("firstAddr", {24'b0, RAM_ADDR}, {24'b0, addr[9:2]});
    n = 0;
    while (STALL === 1'b1 && n < 10) begin
      n++;
      @(negedge CLK);
    end
    checkVal("stallCycles", n, expStall);
  endtask

  task automatic idleCycles(input int k);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    repeat (k) @(posedge CLK);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_STALL"},     {31'b0, STALL},     32'd0);
    checkVal({tag, "_RSP_VALID"}, {31'b0, RSP_VALID}, 32'd0);
    checkVal({tag, "_ACC_ERR"},   {31'b0, ACC_ERR},   32'd0);
    checkVal({tag, "_RAM_RE"},    {31'b0, RAM_RE},    32'd0);
    checkVal({tag, "_RAM_WE"},    {31'b0, RAM_WE},    32'd0);
    checkVal({tag, "_RSP_RDATA"}, RSP_RDATA,          32'd0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    RESET_N    = 1'b0;
    REQ_VALID  = 1'b0;
    REQ_WE     = 1'b0;
    REQ_FUNCT3 = 3'd0;
    REQ_ADDR   = '0;
    REQ_WDATA  = '0;
    #12;
    checkOutput("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    idleCycles(2);

    applyStimulus(1'b0, 3'd2, 10'h014, 32'h0);
    applyStimulus(1'b0, 3'd0, 10'h017, 32'h0);
    applyStimulus(1'b0, 3'd4, 10'h017, 32'h0);
    applyStimulus(1'b0, 3'd1, 10'h016, 32'h0);
    applyStimulus(1'b0, 3'd5, 10'h014, 32'h0);
    applyStimulus(1'b1, 3'd0, 10'h015, 32'h000000AB);
    applyStimulus(1'b0, 3'd2, 10'h014, 32'h0);
    applyStimulus(1'b1, 3'd2, 10'h018, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd2, 10'h018, 32'h0);
    applyStimulus(1'b1, 3'd1, 10'h013, 32'h12345678);
    applyStimulus(1'b0, 3'd2, 10'h016, 32'h0);
    applyStimulus(1'b0, 3'd3, 10'h014, 32'h0);
    applyStimulus(1'b1, 3'd2, 10'h3FC, 32'hCAFEF00D);
    applyStimulus(1'b0, 3'd2, 10'h3FC, 32'h0);
    applyStimulus(1'b1, 3'd1, 10'h3FE, 32'h0000BEEF);
    applyStimulus(1'b0, 3'd1, 10'h3FE, 32'h0);

    // Reset during the write-back cycle of a byte store: nothing may reach memory
    idleCycles(1);
    @(posedge CLK);
    #1;
    REQ_VALID  = 1'b1;
    REQ_WE     = 1'b1;
    REQ_FUNCT3 = 3'd0;
    REQ_ADDR   = 10'h015;
    REQ_WDATA  = 32'h000000CD;
    @(negedge CLK);
    checkVal("rstFirstRe", {31'b0, RAM_RE}, 32'd1);
    @(posedge CLK);
    #1;
    RESET_N   = 1'b0;
    REQ_VALID = 1'b0;
    #1;
    checkOutput("midReset");
    repeat (2) @(negedge CLK);
    checkOutput("heldReset");
    RESET_N = 1'b1;
    applyStimulus(1'b0, 3'd2, 10'h014, 32'h0);
    applyStimulus(1'b1, 3'd2, 10'h020, 32'h0BADC0DE);
    applyStimulus(1'b0, 3'd2, 10'h020, 32'h0);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      addr = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
      if ($urandom_range(0, 5) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      applyStimulus(we, f3, addr, $urandom);
    end

    idleCycles(3);
    checkVal("rspQueueDrained", rspQ.size(), 32'd0);
    checkVal("wrQueueDrained",  wrQ.size(),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
